// File: rtl/mem_lsu.sv
// rtl/mem_lsu.sv - single-outstanding load/store unit with a fixed 2-cycle request-to-response latency.
// Optional feature: define LSU_RANGE_CHECK_EN to fault requests outside [MEM_BASE, MEM_BASE+MEM_BYTES).
module mem_lsu #(
  parameter logic [31:0] MEM_BASE  = 32'h0000_0000,
  parameter int          MEM_BYTES = 32768
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic [1:0]  resp_fault,
  output logic [14:0] mem_addr,
  output logic        mem_cs,
  output logic [1:0]  mem_op,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t      state;
  logic        we_q;
  logic [1:0]  size_q;
  logic        uns_q;
  logic [1:0]  lane_q;
  logic [14:0] off_q;
  logic [31:0] wdata_q;
  logic [1:0]  fault_q;

  logic [14:0] off_in;
  logic        mis_in;
  logic        in_range;
  logic [1:0]  fault_in;

  assign off_in = req_addr[14:0] - MEM_BASE[14:0];

`ifdef LSU_RANGE_CHECK_EN
  logic [31:0] off_full;
  assign off_full = req_addr - MEM_BASE;
  assign in_range = (req_addr >= MEM_BASE) && (off_full < 32'(MEM_BYTES));
`else
  logic unused_cfg;
  assign unused_cfg = ^MEM_BYTES;
  assign in_range   = 1'b1;
`endif

  // Misalignment wins over the range check.
  always_comb begin
    mis_in = ((req_size == 2'b01) && req_addr[0]) ||
             ((req_size == 2'b10) && (req_addr[1:0] != 2'b00)) ||
             (req_size == 2'b11);
    fault_in = 2'b00;
    if (mis_in)
      fault_in = 2'b01;
    else if (!in_range)
      fault_in = 2'b10;
  end

  // RAM strobes are a pure decode of state so the access lands in the cycle after acceptance.
  assign mem_cs    = (state == ACCESS) && (fault_q == 2'b00);
  assign mem_addr  = mem_cs ? off_q : 15'd0;
  assign mem_op    = (mem_cs && we_q) ? (size_q + 2'd1) : 2'b00;
  assign mem_wdata = mem_cs ? wdata_q : 32'd0;

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;
  logic [31:0] load_val;

  assign byte_lane = mem_rdata[{lane_q, 3'b000} +: 8];
  assign half_lane = mem_rdata[{lane_q[1], 4'b0000} +: 16];

  always_comb begin
    load_val = mem_rdata;
    case (size_q)
      2'b00:   load_val = {{24{byte_lane[7] & ~uns_q}}, byte_lane};
      2'b01:   load_val = {{16{half_lane[15] & ~uns_q}}, half_lane};
      default: load_val = mem_rdata;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_rdata <= 32'd0;
      resp_fault <= 2'b00;
      we_q       <= 1'b0;
      size_q     <= 2'b00;
      uns_q      <= 1'b0;
      lane_q     <= 2'b00;
      off_q      <= 15'd0;
      wdata_q    <= 32'd0;
      fault_q    <= 2'b00;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            we_q      <= req_we;
            size_q    <= req_size;
            uns_q     <= req_unsigned;
            lane_q    <= req_addr[1:0];
            off_q     <= off_in;
            wdata_q   <= req_wdata;
            fault_q   <= fault_in;
            req_ready <= 1'b0;
            state     <= ACCESS;
          end
        end
        ACCESS: begin
          resp_valid <= 1'b1;
          resp_fault <= fault_q;
          resp_rdata <= ((fault_q == 2'b00) && !we_q) ? load_val : 32'd0;
          state      <= RESP;
        end
        RESP: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            resp_rdata <= 32'd0;
            resp_fault <= 2'b00;
            req_ready  <= 1'b1;
            state      <= IDLE;
          end
        end
        default: begin
          req_ready <= 1'b1;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule
